// File: rtl/request_unit_pkg.sv
// Shared types for the request unit: the data word and the sequencer state.
package request_unit_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } rqstate_t;

endpackage

// File: rtl/llsc_link.sv
// Load-linked reservation: holds link_valid/link_addr and judges SC success.
// Addresses are compared at word granularity (bits below ADDR_LSB ignored, ADDR_LSB >= 1).
module llsc_link
  import request_unit_pkg::*;
#(
  parameter int ADDR_LSB = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  ll_done_i,
  input  logic  sc_done_i,
  input  logic  st_done_i,
  input  word_t addr_i,
  input  logic  snoop_inv_i,
  input  word_t snoop_addr_i,
  output logic  sc_pass_o
);

  logic                       link_valid_q, link_valid_d;
  logic [WORD_W-1:ADDR_LSB]   link_addr_q, link_addr_d;
  logic                       addr_hit_s;
  logic                       snoop_hit_link_s;
  logic                       snoop_hit_new_s;
  logic                       unused_s;

  assign addr_hit_s       = (link_addr_q == addr_i[WORD_W-1:ADDR_LSB]);
  assign snoop_hit_link_s = snoop_inv_i & (link_addr_q == snoop_addr_i[WORD_W-1:ADDR_LSB]);
  assign snoop_hit_new_s  = snoop_inv_i & (addr_i[WORD_W-1:ADDR_LSB] == snoop_addr_i[WORD_W-1:ADDR_LSB]);
  assign sc_pass_o        = link_valid_q & addr_hit_s;
  assign unused_s         = ^{addr_i[ADDR_LSB-1:0], snoop_addr_i[ADDR_LSB-1:0]};

  // A new LL replaces the reservation unless a snoop kills that very word in the same cycle.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (ll_done_i) begin
      link_addr_d  = addr_i[WORD_W-1:ADDR_LSB];
      link_valid_d = ~snoop_hit_new_s;
    end else if (sc_done_i | snoop_hit_link_s | (st_done_i & addr_hit_s)) begin
      link_valid_d = 1'b0;
    end else begin
      link_valid_d = link_valid_q;
    end
  end

  // Reservation registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

endmodule

// File: rtl/request_unit.sv
// Sequences cache requests and the PC-advance pulse for the single-cycle datapath.
// Define LLSC_EN to build the LL/SC reservation and the failing-SC path.
module request_unit
  import request_unit_pkg::*;
#(
  parameter int ADDR_LSB = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dREN_i,
  input  logic  dWEN_i,
  input  logic  datomic_i,
  input  logic  cpu_halt_i,
  input  word_t dmemaddr_i,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  imemREN,
  output logic  dmemREN,
  output logic  dmemWEN,
  output logic  pc_en,
  output logic  halt,
  output word_t sc_result
);

  rqstate_t state_q, state_d;
  logic     pc_en_s;
  logic     sc_fail_s;
  logic     fail_fire_s;

  // Next state and request strobes; outputs are combinational so pc_en lands in the hit cycle.
  always_comb begin
    state_d = state_q;
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    pc_en_s = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (cpu_halt_i) begin
            state_d = HALTED;
          end else if (sc_fail_s) begin
            pc_en_s = 1'b1;
          end else if (dREN_i | dWEN_i) begin
            state_d = DATA;
          end else begin
            pc_en_s = 1'b1;
          end
        end else begin
          state_d = FETCH;
        end
      end
      DATA: begin
        dmemWEN = dWEN_i;
        dmemREN = dREN_i & ~dWEN_i;
        if (dhit) begin
          pc_en_s = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = DATA;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_en       = pc_en_s & nRST;
  assign halt        = (state_q == HALTED);
  assign fail_fire_s = (state_q == FETCH) & ihit & ~cpu_halt_i & sc_fail_s & nRST;
  assign sc_result   = {{(WORD_W-1){1'b0}}, ~fail_fire_s};

`ifdef LLSC_EN
  logic sc_pass_s;
  logic data_done_s;
  logic ll_done_s;
  logic sc_done_s;
  logic st_done_s;

  assign sc_fail_s   = datomic_i & dWEN_i & ~sc_pass_s;
  assign data_done_s = (state_q == DATA) & dhit;
  assign ll_done_s   = data_done_s & datomic_i & dREN_i & ~dWEN_i;
  assign sc_done_s   = (data_done_s & datomic_i & dWEN_i) | fail_fire_s;
  assign st_done_s   = data_done_s & dWEN_i & ~datomic_i;

  llsc_link #(
    .ADDR_LSB(ADDR_LSB)
  ) u_link (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .ll_done_i   (ll_done_s),
    .sc_done_i   (sc_done_s),
    .st_done_i   (st_done_s),
    .addr_i      (dmemaddr_i),
    .snoop_inv_i (snoop_inv),
    .snoop_addr_i(snoop_addr),
    .sc_pass_o   (sc_pass_s)
  );
`else
  logic unused_s;

  assign sc_fail_s = 1'b0;
  assign unused_s  = ^{datomic_i, snoop_inv, snoop_addr, dmemaddr_i, (ADDR_LSB > 0)};
`endif

endmodule

// File: tb/tb_request_unit.sv
// Directed self-checking bench for request_unit; obs = {imemREN,dmemREN,dmemWEN,pc_en,halt}.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN_i, dWEN_i, datomic_i, cpu_halt_i;
  logic [31:0] dmemaddr_i;
  logic        ihit, dhit, snoop_inv;
  logic [31:0] snoop_addr;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt;
  logic [31:0] sc_result;
  logic [4:0]  obs;
  int          n_checks = 0;
  int          n_fail = 0;

  request_unit #(.ADDR_LSB(2)) dut (
    .CLK(CLK), .nRST(nRST), .dREN_i(dREN_i), .dWEN_i(dWEN_i), .datomic_i(datomic_i),
    .cpu_halt_i(cpu_halt_i), .dmemaddr_i(dmemaddr_i), .ihit(ihit), .dhit(dhit),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .pc_en(pc_en), .halt(halt), .sc_result(sc_result)
  );

  always #5 CLK = ~CLK;
  assign obs = {imemREN, dmemREN, dmemWEN, pc_en, halt};

  // Apply one cycle of inputs on the falling edge and settle before sampling.
  task automatic step(input logic ren, input logic wen, input logic atom, input logic hlt,
                      input logic [31:0] addr, input logic ih, input logic dh);
    @(negedge CLK);
    dREN_i = ren; dWEN_i = wen; datomic_i = atom; cpu_halt_i = hlt;
    dmemaddr_i = addr; ihit = ih; dhit = dh;
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0; datomic_i = 1'b0; cpu_halt_i = 1'b0;
    dmemaddr_i = 32'h0; ihit = 1'b1; dhit = 1'b0; snoop_inv = 1'b0; snoop_addr = 32'h0;
    #2;
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", obs, 5'b10000); end
    n_checks++;
    if (sc_result !== 32'd1) begin n_fail++; $display("FAIL reset_sc_result: got %0d want 1", sc_result); end
    n_checks++;
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_nonmem();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    if (obs !== 5'b10010) begin n_fail++; $display("FAIL nonmem_hit: got %b want %b", obs, 5'b10010); end
    n_checks++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL nonmem_idle: got %b want %b", obs, 5'b10000); end
    n_checks++;
  endtask

  task automatic test_lw();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0);
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL lw_ihit: got %b want %b", obs, 5'b10000); end
    n_checks++;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0);
      if (obs !== 5'b01000) begin n_fail++; $display("FAIL lw_wait%0d: got %b want %b", i, obs, 5'b01000); end
      n_checks++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1);
    if (obs !== 5'b01010) begin n_fail++; $display("FAIL lw_dhit: got %b want %b", obs, 5'b01010); end
    n_checks++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL lw_back_fetch: got %b want %b", obs, 5'b10000); end
    n_checks++;
  endtask

  task automatic test_both_intents();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0);
    if (obs !== 5'b00100) begin n_fail++; $display("FAIL both_wait: got %b want %b", obs, 5'b00100); end
    n_checks++;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1);
    if (obs !== 5'b00110) begin n_fail++; $display("FAIL both_dhit: got %b want %b", obs, 5'b00110); end
    n_checks++;
  endtask

  task automatic test_reset_mid_data();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0);
    if (obs !== 5'b00100) begin n_fail++; $display("FAIL sw_wait: got %b want %b", obs, 5'b00100); end
    n_checks++;
    #1 nRST = 1'b0;
    #1;
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL reset_abort: got %b want %b", obs, 5'b10000); end
    n_checks++;
    @(negedge CLK); nRST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    if (obs !== 5'b10010) begin n_fail++; $display("FAIL after_abort_fetch: got %b want %b", obs, 5'b10010); end
    n_checks++;
  endtask

  task automatic test_halt();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL halt_ihit: got %b want %b", obs, 5'b10000); end
    n_checks++;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (obs !== 5'b00001) begin n_fail++; $display("FAIL halted%0d: got %b want %b", i, obs, 5'b00001); end
      n_checks++;
    end
    #1 nRST = 1'b0;
    #1;
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL halt_cleared: got %b want %b", obs, 5'b10000); end
    n_checks++;
    @(negedge CLK); nRST = 1'b1;
  endtask

  // Run an atomic/plain access at addr through FETCH and one DATA cycle with dhit.
  task automatic mem_op(input logic ren, input logic wen, input logic atom, input logic [31:0] addr);
    step(ren, wen, atom, 1'b0, addr, 1'b1, 1'b0);
    step(ren, wen, atom, 1'b0, addr, 1'b0, 1'b1);
  endtask

`ifdef LLSC_EN
  task automatic test_llsc();
    mem_op(1'b1, 1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL sc1_ihit: got %b want %b", obs, 5'b10000); end
    n_checks++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1);
    if (obs !== 5'b00110) begin n_fail++; $display("FAIL sc1_write: got %b want %b", obs, 5'b00110); end
    n_checks++;
    if (sc_result !== 32'd1) begin n_fail++; $display("FAIL sc1_result: got %0d want 1", sc_result); end
    n_checks++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    if (obs !== 5'b10010) begin n_fail++; $display("FAIL sc2_fail: got %b want %b", obs, 5'b10010); end
    n_checks++;
    if (sc_result !== 32'd0) begin n_fail++; $display("FAIL sc2_result: got %0d want 0", sc_result); end
    n_checks++;
  endtask

  task automatic test_snoop();
    mem_op(1'b1, 1'b0, 1'b1, 32'h200);
    snoop_inv = 1'b1; snoop_addr = 32'h204;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    snoop_inv = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h203, 1'b1, 1'b0);
    if (obs !== 5'b10000) begin n_fail++; $display("FAIL snoop_other_word_sc: got %b want %b", obs, 5'b10000); end
    n_checks++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h203, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 1'b1, 32'h200);
    snoop_inv = 1'b1; snoop_addr = 32'h200;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    snoop_inv = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    if (obs !== 5'b10010 || sc_result !== 32'd0) begin
      n_fail++; $display("FAIL snoop_kill_sc: got %b/%0d want %b/0", obs, sc_result, 5'b10010);
    end
    n_checks++;
    // Invalidate arriving with the LL completion itself.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    snoop_inv = 1'b1; snoop_addr = 32'h200;
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1);
    snoop_inv = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    if (obs !== 5'b10010 || sc_result !== 32'd0) begin
      n_fail++; $display("FAIL snoop_with_ll: got %b/%0d want %b/0", obs, sc_result, 5'b10010);
    end
    n_checks++;
    mem_op(1'b1, 1'b0, 1'b1, 32'h200);
    mem_op(1'b0, 1'b1, 1'b0, 32'h200);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    if (obs !== 5'b10010 || sc_result !== 32'd0) begin
      n_fail++; $display("FAIL store_kill_sc: got %b/%0d want %b/0", obs, sc_result, 5'b10010);
    end
    n_checks++;
  endtask
`else
  task automatic test_no_llsc();
    mem_op(1'b1, 1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
      if (obs !== 5'b10000 || sc_result !== 32'd1) begin
        n_fail++; $display("FAIL plain_sc%0d_ihit: got %b/%0d want %b/1", i, obs, sc_result, 5'b10000);
      end
      n_checks++;
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1);
      if (obs !== 5'b00110 || sc_result !== 32'd1) begin
        n_fail++; $display("FAIL plain_sc%0d_write: got %b/%0d want %b/1", i, obs, sc_result, 5'b00110);
      end
      n_checks++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonmem();
    test_lw();
    test_both_intents();
    test_reset_mid_data();
    test_halt();
`ifdef LLSC_EN
    test_llsc();
    test_snoop();
`else
    test_no_llsc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
